// File: rtl/mci_staged_boot_seqr_pkg.sv
// Shared types for the MCI staged boot sequencer: top FSM and per-domain reset FSM encodings.
package mci_staged_boot_seqr_pkg;

  localparam int unsigned SEQR_STATE_W = 3;
  localparam int unsigned DOM_STATE_W  = 2;

  typedef enum logic [SEQR_STATE_W-1:0] {
    IDLE       = 3'd0,
    STAGE      = 3'd1,
    BRK_CHECK  = 3'd2,
    BREAKPOINT = 3'd3,
    RUN        = 3'd4,
    ERROR      = 3'd5
  } seqr_state_e;

  typedef enum logic [DOM_STATE_W-1:0] {
    HOLD = 2'd0,
    REL  = 2'd1,
    RST  = 2'd2
  } dom_state_e;

endpackage

// File: rtl/caliptra_prim_flop_2sync.sv
// Two-flop synchronizer for asynchronous level inputs.
module caliptra_prim_flop_2sync #(
  parameter int unsigned       Width      = 16,
  parameter logic [Width-1:0]  ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= ResetValue;
      sync_q <= ResetValue;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/mci_rst_domain_ctrl.sv
// One managed reset domain: initial hold, release, level-sensitive reset requests with a
// minimum hold time, and sticky first/hitless classification of the most recent reset.
module mci_rst_domain_ctrl
  import mci_staged_boot_seqr_pkg::*;
#(
  parameter int unsigned MIN_RST_CNT_W = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic go_i,
  input  logic rst_req_i,
  input  logic ready_i,
  output logic rst_b_o,
  output logic first_rst_o,
  output logic hitless_rst_o
);

  dom_state_e               state_q;
  logic [MIN_RST_CNT_W-1:0] cnt_q;
  logic                     once_q;
  logic                     rst_b_q;
  logic                     first_q;
  logic                     hitless_q;
  logic                     elapsed_c;

  assign elapsed_c = &cnt_q;

  // Domain FSM; rst_b_q changes on the same edge as the state it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= HOLD;
      cnt_q     <= '0;
      once_q    <= 1'b0;
      rst_b_q   <= 1'b0;
      first_q   <= 1'b0;
      hitless_q <= 1'b0;
    end else begin
      case (state_q)
        HOLD: begin
          rst_b_q <= 1'b0;
          if (en_i && go_i) begin
            state_q <= REL;
            rst_b_q <= 1'b1;
          end
        end
        REL: begin
          if (en_i && rst_req_i) begin
            state_q   <= RST;
            rst_b_q   <= 1'b0;
            cnt_q     <= '0;
            once_q    <= 1'b1;
            first_q   <= !once_q;
            hitless_q <= once_q;
          end
        end
        RST: begin
          if (!elapsed_c) begin
            cnt_q <= cnt_q + MIN_RST_CNT_W'(1);
          end else if (ready_i) begin
            state_q <= REL;
            rst_b_q <= 1'b1;
          end
        end
        default: begin
          state_q <= HOLD;
          rst_b_q <= 1'b0;
        end
      endcase
    end
  end

  assign rst_b_o       = rst_b_q;
  assign first_rst_o   = first_q;
  assign hitless_rst_o = hitless_q;

endmodule

// File: rtl/mci_staged_boot_seqr.sv
// MCI staged boot sequencer: ordered init/done stages with timeout, optional breakpoint,
// then independent reset-domain management once RUN is reached.
module mci_staged_boot_seqr
  import mci_staged_boot_seqr_pkg::*;
#(
  parameter int unsigned NUM_INIT_STAGES = 2,
  parameter int unsigned NUM_RST_DOMAINS = 2,
  parameter int unsigned MIN_RST_CNT_W   = 4,
  parameter int unsigned TIMEOUT_W       = 16,
  localparam int unsigned IDX_W          = $clog2(NUM_INIT_STAGES + 1)
) (
  input  logic                       clk,
  input  logic                       mci_rst_b,
  input  logic                       scan_mode,
  output logic [NUM_INIT_STAGES-1:0] stage_init,
  input  logic [NUM_INIT_STAGES-1:0] stage_done,
  input  logic                       timeout_en,
  input  logic [TIMEOUT_W-1:0]       timeout_cycles,
  input  logic                       brkpoint,
  input  logic                       bootfsm_go,
  input  logic [NUM_RST_DOMAINS-1:0] dom_go,
  input  logic [NUM_RST_DOMAINS-1:0] dom_rst_req,
  input  logic [NUM_RST_DOMAINS-1:0] dom_ready,
  output logic [NUM_RST_DOMAINS-1:0] dom_rst_b,
  output logic [NUM_RST_DOMAINS-1:0] dom_first_rst,
  output logic [NUM_RST_DOMAINS-1:0] dom_hitless_rst,
  output seqr_state_e                boot_state,
  output logic [IDX_W-1:0]           stage_idx,
  output logic                       err_timeout,
  output logic [IDX_W-1:0]           err_stage
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INIT_STAGES - 1);

  logic [NUM_INIT_STAGES-1:0] done_sync;
  logic                       brk_sync;

  seqr_state_e                state_q;
  logic [IDX_W-1:0]           idx_q;
  logic [NUM_INIT_STAGES-1:0] init_q;
  logic [TIMEOUT_W-1:0]       cnt_q;
  logic                       err_q;
  logic [IDX_W-1:0]           err_stage_q;
  logic [NUM_RST_DOMAINS-1:0] dom_rst_b_q;

  logic                       done_cur_c;
  logic [NUM_INIT_STAGES-1:0] next_init_c;
  logic                       timeout_hit_c;
  logic                       dom_en_c;

  caliptra_prim_flop_2sync #(
    .Width     (NUM_INIT_STAGES),
    .ResetValue('0)
  ) u_done_sync (
    .clk_i (clk),
    .rst_ni(mci_rst_b),
    .d_i   (stage_done),
    .q_o   (done_sync)
  );

  caliptra_prim_flop_2sync #(
    .Width     (1),
    .ResetValue(1'b0)
  ) u_brk_sync (
    .clk_i (clk),
    .rst_ni(mci_rst_b),
    .d_i   (brkpoint),
    .q_o   (brk_sync)
  );

  // Select the active stage's done and build the init bit for the following stage.
  always_comb begin
    done_cur_c  = 1'b0;
    next_init_c = '0;
    for (int i = 0; i < NUM_INIT_STAGES; i++) begin
      if (idx_q == IDX_W'(i)) done_cur_c = done_sync[i];
      if ((idx_q + IDX_W'(1)) == IDX_W'(i)) next_init_c[i] = 1'b1;
    end
  end

  assign timeout_hit_c = timeout_en && (timeout_cycles != '0) &&
                         (cnt_q == (timeout_cycles - TIMEOUT_W'(1)));

  // Top sequencer FSM; a completing done takes priority over a same-cycle timeout.
  always_ff @(posedge clk or negedge mci_rst_b) begin
    if (!mci_rst_b) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      init_q      <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      err_stage_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= STAGE;
          idx_q   <= '0;
          init_q  <= init_q | NUM_INIT_STAGES'(1);
          cnt_q   <= '0;
        end
        STAGE: begin
          if (done_cur_c) begin
            cnt_q <= '0;
            if (idx_q == LAST_IDX) begin
              state_q <= BRK_CHECK;
            end else begin
              idx_q  <= idx_q + IDX_W'(1);
              init_q <= init_q | next_init_c;
            end
          end else if (timeout_hit_c) begin
            state_q     <= ERROR;
            err_q       <= 1'b1;
            err_stage_q <= idx_q;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + TIMEOUT_W'(1);
          end
        end
        BRK_CHECK:  state_q <= brk_sync ? BREAKPOINT : RUN;
        BREAKPOINT: if (bootfsm_go) state_q <= RUN;
        RUN, ERROR: state_q <= state_q;
        default:    state_q <= ERROR;
      endcase
    end
  end

  assign dom_en_c = (state_q == RUN);

  for (genvar d = 0; d < NUM_RST_DOMAINS; d++) begin : g_dom
    mci_rst_domain_ctrl #(
      .MIN_RST_CNT_W(MIN_RST_CNT_W)
    ) u_dom (
      .clk          (clk),
      .rst_n        (mci_rst_b),
      .en_i         (dom_en_c),
      .go_i         (dom_go[d]),
      .rst_req_i    (dom_rst_req[d]),
      .ready_i      (dom_ready[d]),
      .rst_b_o      (dom_rst_b_q[d]),
      .first_rst_o  (dom_first_rst[d]),
      .hitless_rst_o(dom_hitless_rst[d])
    );
  end

  // Scan bypass hands domain resets straight to the chip reset.
  assign dom_rst_b   = scan_mode ? {NUM_RST_DOMAINS{mci_rst_b}} : dom_rst_b_q;
  assign stage_init  = init_q;
  assign stage_idx   = idx_q;
  assign boot_state  = state_q;
  assign err_timeout = err_q;
  assign err_stage   = err_stage_q;

  a_params_legal: assert property (@(posedge clk)
    (NUM_INIT_STAGES > 0) && (NUM_RST_DOMAINS > 0) && (MIN_RST_CNT_W > 0))
    else $error("mci_staged_boot_seqr: illegal parameterisation");

  a_state_known: assert property (@(posedge clk) disable iff (!mci_rst_b)
    !$isunknown(state_q))
    else $error("mci_staged_boot_seqr: boot_state unknown");

endmodule

// File: tb/tb_mci_staged_boot_seqr.sv
// Directed, table-driven bench for mci_staged_boot_seqr (3 stages, 2 domains).
module tb_mci_staged_boot_seqr;
  import mci_staged_boot_seqr_pkg::*;

  localparam int NS = 3;
  localparam int ND = 2;

  logic          clk = 1'b0;
  logic          mci_rst_b;
  logic          scan_mode;
  logic [NS-1:0] stage_init;
  logic [NS-1:0] stage_done;
  logic          timeout_en;
  logic [15:0]   timeout_cycles;
  logic          brkpoint;
  logic          bootfsm_go;
  logic [ND-1:0] dom_go;
  logic [ND-1:0] dom_rst_req;
  logic [ND-1:0] dom_ready;
  logic [ND-1:0] dom_rst_b;
  logic [ND-1:0] dom_first_rst;
  logic [ND-1:0] dom_hitless_rst;
  seqr_state_e   boot_state;
  logic [1:0]    stage_idx;
  logic          err_timeout;
  logic [1:0]    err_stage;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mci_staged_boot_seqr #(
    .NUM_INIT_STAGES(NS),
    .NUM_RST_DOMAINS(ND),
    .MIN_RST_CNT_W  (4),
    .TIMEOUT_W      (16)
  ) dut (
    .clk            (clk),
    .mci_rst_b      (mci_rst_b),
    .scan_mode      (scan_mode),
    .stage_init     (stage_init),
    .stage_done     (stage_done),
    .timeout_en     (timeout_en),
    .timeout_cycles (timeout_cycles),
    .brkpoint       (brkpoint),
    .bootfsm_go     (bootfsm_go),
    .dom_go         (dom_go),
    .dom_rst_req    (dom_rst_req),
    .dom_ready      (dom_ready),
    .dom_rst_b      (dom_rst_b),
    .dom_first_rst  (dom_first_rst),
    .dom_hitless_rst(dom_hitless_rst),
    .boot_state     (boot_state),
    .stage_idx      (stage_idx),
    .err_timeout    (err_timeout),
    .err_stage      (err_stage)
  );

  typedef struct {
    logic [1:0] go;
    logic [1:0] req;
    logic [1:0] ready;
    logic       scan;
    int         cyc;
    logic [1:0] rst_b;
    logic [1:0] first;
    logic [1:0] hitless;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [1:0] go, input logic [1:0] req,
                              input logic [1:0] ready, input logic scan, input int cyc,
                              input logic [1:0] rst_b, input logic [1:0] first,
                              input logic [1:0] hitless);
    vec_t v;
    v.go = go; v.req = req; v.ready = ready; v.scan = scan; v.cyc = cyc;
    v.rst_b = rst_b; v.first = first; v.hitless = hitless;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_state(input seqr_state_e s, input int budget);
    int n = 0;
    while (boot_state !== s && n < budget) begin
      tick();
      n++;
    end
    chk("wait_state", 32'(boot_state), 32'(s));
  endtask

  task automatic do_reset();
    mci_rst_b      = 1'b0;
    scan_mode      = 1'b0;
    stage_done     = '0;
    timeout_en     = 1'b0;
    timeout_cycles = '0;
    brkpoint       = 1'b0;
    bootfsm_go     = 1'b0;
    dom_go         = '0;
    dom_rst_req    = '0;
    dom_ready      = '1;
    repeat (3) tick();
  endtask

  // done seen by the FSM on the third edge after the input rises
  task automatic pulse_done(input int s);
    stage_done[2'(s)] = 1'b1;
    tick();
    stage_done[2'(s)] = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // go, req, ready, scan, cycles, exp rst_b, exp first, exp hitless
    vecs.push_back(mk(2'b00, 2'b00, 2'b11, 1'b0,  3, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(2'b01, 2'b00, 2'b11, 1'b0,  1, 2'b01, 2'b00, 2'b00));
    vecs.push_back(mk(2'b11, 2'b00, 2'b11, 1'b0,  1, 2'b11, 2'b00, 2'b00));
    vecs.push_back(mk(2'b11, 2'b01, 2'b11, 1'b0,  1, 2'b10, 2'b01, 2'b00));
    vecs.push_back(mk(2'b11, 2'b00, 2'b11, 1'b0, 14, 2'b10, 2'b01, 2'b00));
    vecs.push_back(mk(2'b11, 2'b00, 2'b11, 1'b0,  1, 2'b10, 2'b01, 2'b00));
    vecs.push_back(mk(2'b11, 2'b00, 2'b11, 1'b0,  1, 2'b11, 2'b01, 2'b00));
    vecs.push_back(mk(2'b11, 2'b01, 2'b11, 1'b0,  1, 2'b10, 2'b00, 2'b01));
    vecs.push_back(mk(2'b11, 2'b00, 2'b10, 1'b0, 50, 2'b10, 2'b00, 2'b01));
    vecs.push_back(mk(2'b11, 2'b00, 2'b11, 1'b0,  1, 2'b11, 2'b00, 2'b01));
    vecs.push_back(mk(2'b11, 2'b11, 2'b11, 1'b0,  1, 2'b00, 2'b10, 2'b01));
    vecs.push_back(mk(2'b11, 2'b00, 2'b01, 1'b0, 16, 2'b01, 2'b10, 2'b01));
    vecs.push_back(mk(2'b11, 2'b00, 2'b11, 1'b0,  1, 2'b11, 2'b10, 2'b01));
    vecs.push_back(mk(2'b11, 2'b01, 2'b11, 1'b0,  1, 2'b10, 2'b10, 2'b01));
    vecs.push_back(mk(2'b11, 2'b01, 2'b11, 1'b0, 15, 2'b10, 2'b10, 2'b01));
    vecs.push_back(mk(2'b11, 2'b01, 2'b11, 1'b0,  1, 2'b11, 2'b10, 2'b01));
    vecs.push_back(mk(2'b11, 2'b01, 2'b11, 1'b0,  1, 2'b10, 2'b10, 2'b01));
    vecs.push_back(mk(2'b11, 2'b00, 2'b11, 1'b0, 16, 2'b11, 2'b10, 2'b01));
    vecs.push_back(mk(2'b11, 2'b00, 2'b11, 1'b1,  1, 2'b11, 2'b10, 2'b01));
    vecs.push_back(mk(2'b11, 2'b01, 2'b11, 1'b1,  1, 2'b11, 2'b10, 2'b01));
    vecs.push_back(mk(2'b11, 2'b00, 2'b11, 1'b0,  0, 2'b10, 2'b10, 2'b01));
    vecs.push_back(mk(2'b11, 2'b00, 2'b11, 1'b0, 16, 2'b11, 2'b10, 2'b01));

    // Reset values
    do_reset();
    chk("rst_state", 32'(boot_state), 32'(IDLE));
    chk("rst_init", 32'(stage_init), 32'h0);
    chk("rst_idx", 32'(stage_idx), 32'h0);
    chk("rst_dom_rst_b", 32'(dom_rst_b), 32'h0);
    chk("rst_err", 32'(err_timeout), 32'h0);

    // Nominal boot, no breakpoint
    mci_rst_b = 1'b1;
    tick();
    chk("nom_stage", 32'(boot_state), 32'(STAGE));
    chk("nom_init0", 32'(stage_init), 32'h1);
    pulse_done(1);
    chk("ooo_done_ignored", 32'(stage_idx), 32'h0);
    for (int s = 0; s < NS; s++) begin
      repeat (10) tick();
      pulse_done(s);
      if (s < NS - 1) begin
        chk($sformatf("nom_idx%0d", s), 32'(stage_idx), 32'(s + 1));
        chk($sformatf("nom_init%0d", s + 1), 32'(stage_init), (32'h1 << (s + 2)) - 32'h1);
        chk($sformatf("nom_state%0d", s), 32'(boot_state), 32'(STAGE));
      end else begin
        chk("nom_brk_check", 32'(boot_state), 32'(BRK_CHECK));
        chk("nom_init_all", 32'(stage_init), 32'h7);
      end
    end
    tick();
    chk("nom_run", 32'(boot_state), 32'(RUN));
    chk("nom_dom_hold", 32'(dom_rst_b), 32'h0);

    // Domain vectors in RUN
    for (int i = 0; i < vecs.size(); i++) begin
      dom_go      = vecs[i].go;
      dom_rst_req = vecs[i].req;
      dom_ready   = vecs[i].ready;
      scan_mode   = vecs[i].scan;
      repeat (vecs[i].cyc) tick();
      #1;
      chk($sformatf("vec%0d_rst_b", i), 32'(dom_rst_b), 32'(vecs[i].rst_b));
      chk($sformatf("vec%0d_first", i), 32'(dom_first_rst), 32'(vecs[i].first));
      chk($sformatf("vec%0d_hitless", i), 32'(dom_hitless_rst), 32'(vecs[i].hitless));
    end

    // Chip reset while both domains are mid-reset
    dom_rst_req = 2'b11;
    tick();
    dom_rst_req = 2'b00;
    repeat (4) tick();
    chk("midrst_both_low", 32'(dom_rst_b), 32'h0);
    mci_rst_b = 1'b0;
    #1;
    chk("midrst_state", 32'(boot_state), 32'(IDLE));
    chk("midrst_rst_b", 32'(dom_rst_b), 32'h0);
    chk("midrst_first", 32'(dom_first_rst), 32'h0);
    chk("midrst_hitless", 32'(dom_hitless_rst), 32'h0);
    chk("midrst_init", 32'(stage_init), 32'h0);
    scan_mode = 1'b1;
    #1;
    chk("scan_rst_low", 32'(dom_rst_b), 32'h0);
    mci_rst_b = 1'b1;
    #1;
    chk("scan_rst_high_idle", 32'(dom_rst_b), 32'h3);

    // Breakpoint park and resume
    do_reset();
    brkpoint   = 1'b1;
    stage_done = 3'b111;
    mci_rst_b  = 1'b1;
    wait_state(BREAKPOINT, 50);
    dom_go = 2'b11;
    for (int c = 0; c < 100; c++) begin
      tick();
      chk("brk_park_state", 32'(boot_state), 32'(BREAKPOINT));
      chk("brk_park_dom", 32'(dom_rst_b), 32'h0);
    end
    bootfsm_go = 1'b1;
    tick();
    chk("brk_go_run", 32'(boot_state), 32'(RUN));
    tick();
    chk("brk_dom_rel", 32'(dom_rst_b), 32'h3);

    // Timeout on stage 1
    do_reset();
    timeout_en     = 1'b1;
    timeout_cycles = 16'd20;
    dom_go         = 2'b11;
    mci_rst_b      = 1'b1;
    tick();
    pulse_done(0);
    chk("to_idx1", 32'(stage_idx), 32'h1);
    repeat (19) tick();
    chk("to_cycle19_stage", 32'(boot_state), 32'(STAGE));
    chk("to_cycle19_err", 32'(err_timeout), 32'h0);
    tick();
    chk("to_error_state", 32'(boot_state), 32'(ERROR));
    chk("to_err_flag", 32'(err_timeout), 32'h1);
    chk("to_err_stage", 32'(err_stage), 32'h1);
    repeat (5) tick();
    chk("to_error_sticky", 32'(boot_state), 32'(ERROR));
    chk("to_dom_low", 32'(dom_rst_b), 32'h0);
    chk("to_init_held", 32'(stage_init), 32'h3);

    // Done arriving in the timeout cycle wins
    do_reset();
    timeout_en     = 1'b1;
    timeout_cycles = 16'd20;
    mci_rst_b      = 1'b1;
    tick();
    pulse_done(0);
    chk("dw_idx1", 32'(stage_idx), 32'h1);
    repeat (17) tick();
    stage_done[1] = 1'b1;
    repeat (2) tick();
    chk("dw_cycle19", 32'(boot_state), 32'(STAGE));
    tick();
    stage_done[1] = 1'b0;
    chk("dw_state", 32'(boot_state), 32'(STAGE));
    chk("dw_idx2", 32'(stage_idx), 32'h2);
    chk("dw_no_err", 32'(err_timeout), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
